// File: rtl/alu.sv
// N-bit ALU with a combinational result/zero path and a registered {V,C,N,Z} flag word.
// RESULT and ZERO depend only on A, B and OP; FLAGS captures the live flags each CLK edge.
module alu #(
  parameter int unsigned N = 32
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   OP,
  output logic [N-1:0] RESULT,
  output logic         ZERO,
  output logic [3:0]   FLAGS
);

  localparam int unsigned SW = $clog2(N);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic [N:0]    sum;
  logic [N:0]    diff;
  logic [SW-1:0] shamt;
  logic          lt_s;
  logic          lt_u;
  logic [N-1:0]  res_c;
  logic          carry_c;
  logic          ovf_c;
  logic [3:0]    flags_d;
  logic [3:0]    flags_q;

  // Operation select; carry and overflow are only meaningful for ADD/SUB
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    shamt   = B[SW-1:0];
    lt_s    = $signed(A) < $signed(B);
    lt_u    = A < B;
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (OP)
      OP_ADD: begin
        res_c   = sum[N-1:0];
        carry_c = sum[N];
        ovf_c   = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
      end
      OP_SUB: begin
        res_c   = diff[N-1:0];
        carry_c = ~diff[N];
        ovf_c   = (A[N-1] != B[N-1]) && (diff[N-1] != A[N-1]);
      end
      OP_SLL:  res_c = A << shamt;
      OP_SLT:  res_c = {{(N-1){1'b0}}, lt_s};
      OP_SLTU: res_c = {{(N-1){1'b0}}, lt_u};
      OP_XOR:  res_c = A ^ B;
      OP_SRL:  res_c = A >> shamt;
      OP_SRA:  res_c = N'($signed(A) >>> shamt);
      OP_OR:   res_c = A | B;
      OP_AND:  res_c = A & B;
      default: res_c = '0;
    endcase
    flags_d = {ovf_c, carry_c, res_c[N-1], (res_c == '0)};
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign RESULT = res_c;
  assign ZERO   = (res_c == '0);
  assign FLAGS  = flags_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes model expectations, a monitor pops and compares
// RESULT/ZERO mid-cycle and the matching FLAGS one edge later.
module tb_alu;

  localparam int unsigned W      = 32;
  localparam int unsigned NRAND  = 9000;
  localparam longint      MAXS   = (64'sd1 <<< 31) - 64'sd1;
  localparam longint      MINS   = -(64'sd1 <<< 31);

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic [3:0]   f;
  } exp_t;

  logic         CLK;
  logic         RESET_N;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [3:0]   OP;
  logic [W-1:0] RESULT;
  logic         ZERO;
  logic [3:0]   FLAGS;

  int   checks = 0;
  int   errors = 0;
  exp_t res_q[$];

  alu #(.N(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .A(A), .B(B), .OP(OP),
    .RESULT(RESULT), .ZERO(ZERO), .FLAGS(FLAGS)
  );

  initial begin
    CLK = 1'b0;
    forever #20 CLK = ~CLK;
  end

  // Reference: plain 64-bit integer arithmetic on the operation definitions
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    int              sh = int'(b[4:0]);
    longint unsigned r  = 0;
    longint          sr;
    logic            c  = 1'b0;
    logic            v  = 1'b0;
    exp_t            e;
    case (op)
      4'b0000: begin
        r = ua + ub;
        c = (r >= (64'd1 << 32));
        sr = sa + sb;
        v = (sr > MAXS) || (sr < MINS);
      end
      4'b1000: begin
        r = ua - ub;
        c = (ua >= ub);
        sr = sa - sb;
        v = (sr > MAXS) || (sr < MINS);
      end
      4'b0001: r = ua << sh;
      4'b0010: r = (sa < sb) ? 64'd1 : 64'd0;
      4'b0011: r = (ua < ub) ? 64'd1 : 64'd0;
      4'b0100: r = ua ^ ub;
      4'b0101: r = ua >> sh;
      4'b1101: r = 64'(sa >>> sh);
      4'b0110: r = ua | ub;
      4'b0111: r = ua & ub;
      default: r = 0;
    endcase
    e.res = r[W-1:0];
    e.z   = (e.res == '0);
    e.f   = {v, c, e.res[W-1], e.z};
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    OP = op;
    A  = a;
    B  = b;
  endtask

  // One vector per cycle, applied 2 ns after the rising edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge CLK);
    #2;
    drive(op, a, b);
    res_q.push_back(model(op, a, b));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] corners [5] = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF,
                                  32'h8000_0000, 32'hFFFF_FFFF};
    case ($urandom_range(0, 3))
      0, 1:    return $urandom;
      2:       return corners[$urandom_range(0, 4)];
      default: return W'($urandom_range(0, 40));
    endcase
  endfunction

  // Monitor: flags for the previous vector at edge+1, result/zero 16 ns after application
  initial begin
    exp_t cur;
    logic [3:0] flag_exp;
    logic       flag_pend;
    flag_pend = 1'b0;
    flag_exp  = 4'b0000;
    forever begin
      @(posedge CLK);
      #1;
      if (flag_pend && RESET_N) chk("flags", W'(FLAGS), W'(flag_exp));
      flag_pend = 1'b0;
      #17;
      if (res_q.size() > 0) begin
        cur = res_q.pop_front();
        chk("result", RESULT, cur.res);
        chk("zero", W'(ZERO), W'(cur.z));
        flag_exp  = cur.f;
        flag_pend = 1'b1;
      end
    end
  end

  initial begin
    exp_t e;
    int   guard;
    RESET_N = 1'b0;
    drive(4'b1000, 32'd5, 32'd3);
    #5;
    chk("reset_flags", W'(FLAGS), '0);
    chk("reset_result", RESULT, 32'd2);
    @(posedge CLK);
    #1;
    chk("reset_flags_edge", W'(FLAGS), '0);
    #9;
    RESET_N = 1'b1;

    issue(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(4'b1000, 32'h8000_0000, 32'h0000_0001);
    issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001);
    issue(4'b1101, 32'h8000_0000, 32'h0000_0024);
    issue(4'b0101, 32'h8000_0000, 32'h0000_0024);
    issue(4'b0001, 32'h0000_0001, 32'h0000_001F);
    issue(4'b0001, 32'h1234_5678, 32'hFFFF_FFE0);
    issue(4'b0111, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    issue(4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(4'b1001, 32'h0000_0001, 32'h0000_0001);
    issue(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(4'b1000, 32'h0000_0003, 32'h0000_0003);

    for (int i = 0; i < NRAND; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
    end

    // Asynchronous reset while FLAGS holds a non-zero value
    @(posedge CLK);
    #2;
    drive(4'b1000, 32'h8000_0000, 32'h0000_0001);
    @(posedge CLK);
    #1;
    chk("pre_reset_flags", W'(FLAGS), W'(4'b1100));
    #9;
    RESET_N = 1'b0;
    #1;
    chk("async_reset_flags", W'(FLAGS), '0);
    chk("async_reset_result", RESULT, 32'h7FFF_FFFF);
    drive(4'b1000, 32'h0000_0000, 32'h0000_0001);
    #1;
    chk("reset_tracks_result", RESULT, 32'hFFFF_FFFF);
    chk("reset_tracks_zero", W'(ZERO), '0);
    @(posedge CLK);
    #1;
    chk("reset_hold_flags", W'(FLAGS), '0);
    #9;
    RESET_N = 1'b1;
    #1;
    chk("release_no_update", W'(FLAGS), '0);
    e = model(4'b1000, 32'h0000_0000, 32'h0000_0001);
    @(posedge CLK);
    #1;
    chk("release_first_capture", W'(FLAGS), W'(e.f));

    guard = 0;
    while (res_q.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    if (res_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expected 0", res_q.size());
    end
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
